// File: rtl/pulse_sequencer_if.sv
// Host-side bundle for pulse_sequencer: start/stop handshake, timing configuration and status.
interface pulse_sequencer_if #(
    parameter int CNT_W   = 11,
    parameter int BURST_W = 8
);
    logic               START;
    logic               STOP;
    logic [CNT_W-1:0]   PERIOD_CFG;
    logic [CNT_W-1:0]   WIDTH_A_CFG;
    logic [CNT_W-1:0]   DELAY_B_CFG;
    logic [CNT_W-1:0]   WIDTH_B_CFG;
    logic [BURST_W-1:0] BURST_CFG;
    logic               PULSE_A;
    logic               PULSE_B;
    logic               BUSY;
    logic               DONE;
    logic               CFG_ERR;
    logic [BURST_W-1:0] PULSE_IDX;

    modport master (
        output START, STOP, PERIOD_CFG, WIDTH_A_CFG, DELAY_B_CFG, WIDTH_B_CFG, BURST_CFG,
        input  PULSE_A, PULSE_B, BUSY, DONE, CFG_ERR, PULSE_IDX
    );
    modport slave (
        input  START, STOP, PERIOD_CFG, WIDTH_A_CFG, DELAY_B_CFG, WIDTH_B_CFG, BURST_CFG,
        output PULSE_A, PULSE_B, BUSY, DONE, CFG_ERR, PULSE_IDX
    );
endinterface

// File: rtl/pulse_sequencer.sv
// Two-channel programmable pulse-train sequencer: burst or continuous periods from one phase counter,
// graceful STOP at period end, registered outputs derived from the next-state phase.
module pulse_sequencer #(
    parameter int CNT_W   = 11,
    parameter int BURST_W = 8
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    pulse_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]   per;
        logic [CNT_W-1:0]   wa;
        logic [CNT_W-1:0]   db;
        logic [CNT_W-1:0]   wb;
        logic [BURST_W-1:0] n;
    } cfg_t;

    state_t             state_q, state_d;
    cfg_t               cfg_q, cfg_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [BURST_W-1:0] idx_q, idx_d;
    logic               pend_q, pend_d;
    logic               rst_sync_n;
    logic               last_period;
    logic               pulse_a_q, pulse_b_q, busy_q, done_q, cfg_err_q;
    logic               pulse_a_d, pulse_b_d, busy_d, done_d, cfg_err_d;

    // Assertion is immediate; release takes one edge so START is first seen on the second edge.
    always_ff @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) rst_sync_n <= 1'b0;
        else          rst_sync_n <= 1'b1;

    always_ff @(posedge CLOCK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            phase_q   <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            pulse_a_q <= 1'b0;
            pulse_b_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pulse_a_q <= pulse_a_d;
            pulse_b_q <= pulse_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign last_period = pend_q || bus.STOP ||
                         ((cfg_q.n != '0) && (idx_q == cfg_q.n - BURST_W'(1)));

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (bus.START && (bus.PERIOD_CFG >= CNT_W'(2))) begin
                    state_d = RUN;
                    cfg_d   = '{per: bus.PERIOD_CFG, wa: bus.WIDTH_A_CFG, db: bus.DELAY_B_CFG,
                                wb: bus.WIDTH_B_CFG, n: bus.BURST_CFG};
                    phase_d = '0;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            RUN: begin
                if (phase_q == cfg_q.per - CNT_W'(1)) begin
                    if (last_period) begin
                        state_d = FIN;
                    end else begin
                        phase_d = '0;
                        idx_d   = idx_q + BURST_W'(1);
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                    if (bus.STOP) pend_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // B window end is widened by one bit so D_B+W_B never wraps; phase < P clips it at period end.
    always_comb begin
        busy_d    = (state_d == RUN);
        done_d    = (state_d == FIN);
        pulse_a_d = busy_d && (phase_d < cfg_d.wa);
        pulse_b_d = busy_d && (phase_d >= cfg_d.db) &&
                    ({1'b0, phase_d} < ({1'b0, cfg_d.db} + {1'b0, cfg_d.wb}));
        cfg_err_d = (state_q == IDLE) && bus.START && (bus.PERIOD_CFG < CNT_W'(2));
    end

    assign bus.PULSE_A   = pulse_a_q;
    assign bus.PULSE_B   = pulse_b_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.CFG_ERR   = cfg_err_q;
    assign bus.PULSE_IDX = idx_q;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Randomized self-checking bench for pulse_sequencer against a per-cycle arithmetic reference model.
module tb_pulse_sequencer;
    localparam int CNT_W   = 11;
    localparam int BURST_W = 8;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       cerr;
        logic [7:0] idx;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    int   m_p, m_wa, m_db, m_wb, m_periods, m_len;
    obs_t obs [0:1023];

    pulse_sequencer_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    pulse_sequencer #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return '{a: bus.PULSE_A, b: bus.PULSE_B, busy: bus.BUSY, done: bus.DONE,
                 cerr: bus.CFG_ERR, idx: bus.PULSE_IDX};
    endfunction

    // Cycle c counts from the cycle right after the accepting edge.
    function automatic obs_t ref_at(input int c);
        obs_t e;
        int   busy_c;
        int   ph;
        e = '0;
        busy_c = m_periods * m_p;
        if (c < busy_c) begin
            ph     = c % m_p;
            e.busy = 1'b1;
            e.a    = (ph < m_wa);
            e.b    = (ph >= m_db) && (ph < m_db + m_wb);
            e.idx  = 8'((c / m_p) % (1 << BURST_W));
        end else begin
            e.done = (c == busy_c);
            e.idx  = 8'((m_periods - 1) % (1 << BURST_W));
        end
        return e;
    endfunction

    task automatic scramble_cfg();
        bus.PERIOD_CFG  = 11'($urandom_range(0, 2047));
        bus.WIDTH_A_CFG = 11'($urandom_range(0, 2047));
        bus.DELAY_B_CFG = 11'($urandom_range(0, 2047));
        bus.WIDTH_B_CFG = 11'($urandom_range(0, 2047));
        bus.BURST_CFG   = 8'($urandom_range(0, 255));
    endtask

    // Starts one sequence and records every cycle through one idle cycle after DONE.
    task automatic run_capture(input int p, input int wa, input int db, input int wb,
                               input int n, input int stop_c);
        int per;
        per = (n == 0) ? 100000 : n;
        if (stop_c >= 0 && (stop_c / p + 1) < per) per = stop_c / p + 1;
        m_p = p; m_wa = wa; m_db = db; m_wb = wb; m_periods = per;
        m_len = per * p + 2;
        @(negedge clk);
        bus.START       = 1'b1;
        bus.STOP        = 1'($urandom_range(0, 1));
        bus.PERIOD_CFG  = 11'(p);
        bus.WIDTH_A_CFG = 11'(wa);
        bus.DELAY_B_CFG = 11'(db);
        bus.WIDTH_B_CFG = 11'(wb);
        bus.BURST_CFG   = 8'(n);
        for (int c = 0; c < m_len; c++) begin
            @(negedge clk);
            obs[c]    = sample();
            bus.START = (c < m_len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.STOP  = (c == stop_c) ? 1'b1 :
                        (c >= m_len - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            scramble_cfg();
        end
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
    endtask

    task automatic test_reset();
        bus.START = 1'b1;
        bus.STOP  = 1'b0;
        scramble_cfg();
        bus.PERIOD_CFG = 11'd10;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sample() !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", sample(), obs_t'(0));
        end
        bus.START = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst();
        run_capture(10, 3, 5, 2, 2, -1);
        for (int c = 0; c < m_len; c++) begin
            vectors++;
            if (obs[c] !== ref_at(c)) begin
                miscompares++;
                $display("FAIL burst cyc %0d got %h want %h", c, obs[c], ref_at(c));
            end
        end
    endtask

    task automatic test_stop();
        run_capture(4, 1, 0, 0, 0, 9);
        for (int c = 0; c < m_len; c++) begin
            vectors++;
            if (obs[c] !== ref_at(c)) begin
                miscompares++;
                $display("FAIL stop cyc %0d got %h want %h", c, obs[c], ref_at(c));
            end
        end
        // 258 continuous periods so PULSE_IDX wraps through 255 -> 0
        run_capture(2, 1, 1, 1, 0, 2 * 257 + 1);
        for (int c = 0; c < m_len; c++) begin
            vectors++;
            if (obs[c] !== ref_at(c)) begin
                miscompares++;
                $display("FAIL idx_wrap cyc %0d got %h want %h", c, obs[c], ref_at(c));
            end
        end
    endtask

    task automatic test_clip();
        run_capture(8, 2, 6, 5, 2, -1);
        for (int c = 0; c < m_len; c++) begin
            vectors++;
            if (obs[c] !== ref_at(c)) begin
                miscompares++;
                $display("FAIL clip cyc %0d got %h want %h", c, obs[c], ref_at(c));
            end
        end
    endtask

    task automatic test_cfg_err();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            scramble_cfg();
            bus.START      = 1'b1;
            bus.PERIOD_CFG = 11'(k);
            @(negedge clk);
            bus.START = 1'b0;
            vectors++;
            if ({bus.CFG_ERR, bus.BUSY, bus.PULSE_A, bus.PULSE_B} !== 4'b1000) begin
                miscompares++;
                $display("FAIL cfg_err_strobe P=%0d got err/busy/a/b %b want 1000", k,
                         {bus.CFG_ERR, bus.BUSY, bus.PULSE_A, bus.PULSE_B});
            end
            @(negedge clk);
            vectors++;
            if ({bus.CFG_ERR, bus.BUSY} !== 2'b00) begin
                miscompares++;
                $display("FAIL cfg_err_one_cycle got err/busy %b want 00", {bus.CFG_ERR, bus.BUSY});
            end
        end
        run_capture(2, 1, 0, 0, 1, -1);
        for (int c = 0; c < m_len; c++) begin
            vectors++;
            if (obs[c] !== ref_at(c)) begin
                miscompares++;
                $display("FAIL min_period cyc %0d got %h want %h", c, obs[c], ref_at(c));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t got;
        @(negedge clk);
        bus.START = 1'b1; bus.STOP = 1'b0;
        bus.PERIOD_CFG = 11'd10; bus.WIDTH_A_CFG = 11'd5;
        bus.DELAY_B_CFG = 11'd0; bus.WIDTH_B_CFG = 11'd8; bus.BURST_CFG = 8'd0;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            bus.START = 1'b0;
        end
        vectors++;
        got = sample();
        if (got !== obs_t'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1})) begin
            miscompares++;
            $display("FAIL pre_reset_run got %h want %h", got, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (sample() !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL async_reset got %h want %h", sample(), obs_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.START = 1'b1;
        bus.PERIOD_CFG = 11'd2; bus.WIDTH_A_CFG = 11'd1; bus.BURST_CFG = 8'd1;
        bus.WIDTH_B_CFG = 11'd0;
        @(negedge clk);
        vectors++;
        if (bus.BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL release_edge1 got busy %b want 0", bus.BUSY);
        end
        @(negedge clk);
        bus.START = 1'b0;
        vectors++;
        got = sample();
        if (got !== obs_t'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0})) begin
            miscompares++;
            $display("FAIL release_edge2 got %h want %h", got, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_edge_cases();
        int p_l[4]  = '{10, 6, 7, 5};
        int wa_l[4] = '{4, 0, 7, 2};
        int n_l[4]  = '{1, 1, 2, 2};
        int st_l[4] = '{-1, -1, -1, 9};
        for (int t = 0; t < 4; t++) begin
            run_capture(p_l[t], wa_l[t], 2, 3, n_l[t], st_l[t]);
            for (int c = 0; c < m_len; c++) begin
                vectors++;
                if (obs[c] !== ref_at(c)) begin
                    miscompares++;
                    $display("FAIL edge%0d cyc %0d got %h want %h", t, c, obs[c], ref_at(c));
                end
            end
        end
    endtask

    task automatic test_random();
        int p, wa, db, wb, n, st;
        for (int it = 0; it < 16; it++) begin
            p  = $urandom_range(2, 20);
            wa = $urandom_range(0, p + 2);
            db = $urandom_range(0, p + 2);
            wb = ($urandom_range(0, 3) == 0) ? 2047 : $urandom_range(0, p + 2);
            n  = $urandom_range(0, 4);
            st = (n == 0 || $urandom_range(0, 1) == 1) ?
                 $urandom_range(0, ((n == 0) ? 4 : n) * p - 1) : -1;
            run_capture(p, wa, db, wb, n, st);
            for (int c = 0; c < m_len; c++) begin
                vectors++;
                if (obs[c] !== ref_at(c)) begin
                    miscompares++;
                    $display("FAIL random%0d cyc %0d got %h want %h", it, c, obs[c], ref_at(c));
                end
            end
        end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        scramble_cfg();
        test_reset();
        test_burst();
        test_stop();
        test_clip();
        test_cfg_err();
        test_reset_mid_run();
        test_edge_cases();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Programmable two-channel pulse-train controller that sequences burst and continuous pulse generation from a shared phase counter. Software or a host FSM loads period, widths, channel-B delay and burst count, then issues START. The block produces PULSE_A and PULSE_B for a fixed number of periods, or until STOP, and reports BUSY/DONE. It replaces fixed-constant pulse generators wherever timing must be configurable at run time.

## Interface
- CNT_W, 11, width of phase counter and of all timing config fields
- BURST_W, 8, width of burst count and period index
- CLOCK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  request to start a sequence; sampled only in IDLE
- STOP  in  1  graceful stop request; sampled only in RUN
- PERIOD_CFG  in  CNT_W  period length P in cycles
- WIDTH_A_CFG  in  CNT_W  channel A high width W_A
- DELAY_B_CFG  in  CNT_W  channel B start phase D_B
- WIDTH_B_CFG  in  CNT_W  channel B high width W_B
- BURST_CFG  in  BURST_W  number of periods N; 0 = continuous
- PULSE_A  out  1  channel A pulse, registered
- PULSE_B  out  1  channel B pulse, registered
- BUSY  out  1  high while in RUN
- DONE  out  1  one-cycle completion strobe
- CFG_ERR  out  1  one-cycle strobe, START rejected
- PULSE_IDX  out  BURST_W  0-based index of current period

## Operation
- States: IDLE, RUN, FIN.
- IDLE: PULSE_A=PULSE_B=BUSY=DONE=0. On START=1:
  - if PERIOD_CFG < 2: CFG_ERR=1 for one cycle, remain IDLE, no config latched.
  - else latch all *_CFG fields, phase=0, PULSE_IDX=0, stop_pend=0, go RUN.
- Config inputs are ignored outside the START-accept edge. Changes during RUN have no effect.
- RUN: phase counts 0..P-1.
  - PULSE_A = (phase < W_A). W_A=0 gives never high. W_A>=P gives high for the whole period.
  - PULSE_B = (phase >= D_B) && (phase < D_B+W_B). The sum is computed in CNT_W+1 bits with no wrap. The pulse is clipped at the period end and never spills into the next period's phase 0.
- End of period (phase = P-1):
  - if stop_pend, or STOP=1 this cycle, or (N != 0 and PULSE_IDX = N-1): go FIN.
  - else phase=0 and PULSE_IDX increments. In continuous mode PULSE_IDX wraps from 2^BURST_W-1 to 0.
- STOP=1 in RUN at any other phase sets stop_pend. The current period always completes. STOP is never an abort.
- FIN: DONE=1, BUSY=0, pulses 0, one cycle, then IDLE. START in FIN is ignored.
- PULSE_IDX holds its final value through FIN and IDLE until the next accepted START.
- STOP in IDLE or FIN is ignored. STOP sampled on the same edge START is accepted is ignored.
- Reset: all outputs 0, PULSE_IDX=0, state IDLE, immediately on RESET_N low, mid-run included. Release is synchronised to CLOCK internally; first START is accepted on the second edge after release.

## Timing
- START sampled high at edge t0 in IDLE → from t0: BUSY=1, phase=0, PULSE_A=(W_A>0), PULSE_B=(D_B=0 && W_B>0). First pulse visible one cycle after START.
- Outputs are registered from next-state phase. PULSE_A/PULSE_B in a given cycle correspond exactly to that cycle's phase, with no extra lag.
- A sequence of N periods occupies exactly N*P cycles with BUSY=1, followed by one DONE cycle. The earliest next START accept is the edge after DONE.
- CFG_ERR is asserted the cycle after the rejected START edge.

## Test plan
- Burst: P=10, W_A=3, D_B=5, W_B=2, N=2, START at edge 0 → PULSE_A high cycles 1-3 and 11-13; PULSE_B high cycles 6-7 and 16-17; BUSY high cycles 1-20; DONE high cycle 21 only; PULSE_IDX=1 afterwards.
- Continuous + STOP: P=4, W_A=1, N=0, STOP pulsed at phase 1 of period index 2 → period 2 completes (4 cycles); DONE next cycle; PULSE_IDX=2; exactly 3 PULSE_A pulses.
- Clipping: P=8, D_B=6, W_B=5, N=2 → PULSE_B high phases 6-7 only in each period; low at phase 0 of period 1.
- Config error: PERIOD_CFG=1 with START → CFG_ERR high one cycle, BUSY stays 0, no pulses. Then PERIOD_CFG=2, W_A=1, N=1 → one 1-cycle PULSE_A, DONE after 2 busy cycles.
- Reset mid-run: assert RESET_N low during phase 3 of P=10 with PULSE_A high → all outputs 0 asynchronously. After release, START succeeds with PULSE_IDX=0.
- Config hold and edge cases: change PERIOD_CFG from 10 to 5 during RUN → period stays 10. W_A=0 → PULSE_A never high. W_A=P → PULSE_A constant high while BUSY. STOP at phase P-1 of the final burst period → single DONE, no extra period.
